// File: rtl/sd_adc_decimator.sv
// sd_adc_decimator: closes a 1st-order delta-sigma ADC loop around an external
// comparator/RC integrator and decimates the resulting bitstream with a
// 2nd-order CIC into excess-2^(OUT_W-1) PCM. Also provides a hysteresis EAR bit.
module sd_adc_decimator #(
  parameter int unsigned DECIM_LOG2 = 6,
  parameter int unsigned OUT_W      = 9,
  parameter int unsigned HYST       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             sd_in,
  output logic             sd_fb,
  output logic [OUT_W-1:0] sample,
  output logic             sample_valid,
  output logic             ear
);

  localparam int unsigned W     = 2*DECIM_LOG2 + 1;
  localparam int unsigned SHIFT = 2*DECIM_LOG2 - OUT_W;

  localparam logic [OUT_W-1:0] MID   = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W:0]   HI_TH = (OUT_W+1)'(2**(OUT_W-1) + HYST);
  localparam logic [OUT_W:0]   LO_TH = (OUT_W+1)'(2**(OUT_W-1) - HYST);

  // Warm-up sequencing: the comb delays need two decimation events to prime.
  typedef enum logic [1:0] {
    WARM0 = 2'd0,
    WARM1 = 2'd1,
    RUN   = 2'd2
  } warm_t;

  logic                  s1_q, s2_q, fb_q;
  logic [W-1:0]          i1_q, i2_q, d1_q, d2_q;
  logic [DECIM_LOG2-1:0] dcnt_q;
  warm_t                 warm_q;
  logic [OUT_W-1:0]      sample_q;
  logic                  valid_q;
  logic                  ear_q;

  logic [W-1:0]          b_ext;
  logic [W-1:0]          c1, c2, c2_sh;
  logic                  dec_evt;
  logic [OUT_W-1:0]      q_sat;
  logic                  ear_d;

  // Comb section of the CIC, output scaling/saturation and EAR hysteresis decision.
  always_comb begin
    b_ext   = {{(W-1){1'b0}}, fb_q};
    dec_evt = (dcnt_q == '1);
    c1      = i2_q - d1_q;
    c2      = c1 - d2_q;
    c2_sh   = c2 >> SHIFT;
    // Full-scale ones density yields exactly 2^OUT_W after scaling; clamp it.
    q_sat   = (c2_sh[W-1:OUT_W] != '0) ? '1 : c2_sh[OUT_W-1:0];
    ear_d   = ear_q;
    if ({1'b0, q_sat} >= HI_TH) begin
      ear_d = 1'b1;
    end else if ({1'b0, q_sat} <= LO_TH) begin
      ear_d = 1'b0;
    end
  end

  // Comparator synchroniser, feedback register and free-running CIC integrators (mod 2^W).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      fb_q <= 1'b0;
      i1_q <= '0;
      i2_q <= '0;
    end else begin
      s1_q <= sd_in;
      s2_q <= s1_q;
      fb_q <= s2_q;
      i1_q <= i1_q + b_ext;
      i2_q <= i2_q + i1_q;
    end
  end

  // Decimation counter, comb delay registers, warm-up FSM and registered sample outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      dcnt_q   <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      warm_q   <= WARM0;
      sample_q <= MID;
      valid_q  <= 1'b0;
      ear_q    <= 1'b0;
    end else begin
      dcnt_q  <= dcnt_q + {{(DECIM_LOG2-1){1'b0}}, 1'b1};
      valid_q <= 1'b0;
      if (dec_evt) begin
        d1_q <= i2_q;
        d2_q <= c1;
        case (warm_q)
          WARM0:   warm_q <= WARM1;
          WARM1:   warm_q <= RUN;
          default: begin
            sample_q <= q_sat;
            valid_q  <= 1'b1;
            ear_q    <= ear_d;
          end
        endcase
      end
    end
  end

  assign sd_fb        = fb_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign ear          = ear_q;

endmodule

// File: tb/tb_sd_adc_decimator.sv
// tb_sd_adc_decimator: directed density patterns drive sd_in; a window-sum
// reference pushes expected samples into a queue that a negedge monitor drains.
module tb_sd_adc_decimator;

  localparam int unsigned DL = 6;
  localparam int unsigned OW = 9;
  localparam int unsigned HY = 16;
  localparam int          R  = 64;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          sd_in = 1'b0;
  logic          sd_fb;
  logic [OW-1:0] sample;
  logic          sample_valid;
  logic          ear;

  sd_adc_decimator #(
    .DECIM_LOG2 (DL),
    .OUT_W      (OW),
    .HYST       (HY)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .sd_in        (sd_in),
    .sd_fb        (sd_fb),
    .sample       (sample),
    .sample_valid (sample_valid),
    .ear          (ear)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [OW-1:0] smp;
    logic          e;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int          cyc     = 0;
  bit          xh [0:32767];
  bit          ear_m   = 1'b0;
  int          last_v  = 0;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Bit seen by the CIC at edge w: sd_in captured three edges earlier.
  function automatic int bval(input int w);
    if (w < 4) return 0;
    return int'(xh[w-3]);
  endfunction

  // Reference: CIC2 output as a sum of 64 overlapping 64-sample ones counts.
  initial begin : model
    int c2;
    int q;
    forever begin
      @(posedge Clk);
      if (Reset) begin
        if (cyc != 0) chk("pending_at_reset", exp_q.size(), 0);
        exp_q.delete();
        cyc   = 0;
        ear_m = 1'b0;
      end else begin
        cyc++;
        if (cyc < 32768) xh[cyc] = sd_in;
        if ((cyc % R == 0) && (cyc >= 3*R)) begin
          c2 = 0;
          for (int v = cyc-65; v <= cyc-2; v++)
            for (int w = v-63; w <= v; w++)
              c2 += bval(w);
          q = c2 >> 3;
          if (q > 511) q = 511;
          if (q >= 256 + int'(HY))      ear_m = 1'b1;
          else if (q <= 256 - int'(HY)) ear_m = 1'b0;
          exp_q.push_back('{smp: OW'(q), e: ear_m});
        end
      end
    end
  end

  // Monitor: compares each strobe against the scoreboard, checks timing and warm-up.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: got sample %0d with no expected entry (cycle %0d)", sample, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("sample", int'(sample), int'(e.smp));
          chk("ear", int'(ear), int'(e.e));
        end
        if (last_v != 0) chk("valid_period", cyc - last_v, R);
        else             chk("first_valid_cycle", cyc, 3*R);
        last_v = cyc;
      end
      if (Reset) begin
        last_v = 0;
      end else if (!sample_valid && last_v == 0) begin
        chk("warmup_sample", int'(sample), 256);
        chk("warmup_ear", int'(ear), 0);
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_sd_fb"}, int'(sd_fb), 0);
    chk({tag, "_sample"}, int'(sample), 256);
    chk({tag, "_valid"}, int'(sample_valid), 0);
    chk({tag, "_ear"}, int'(ear), 0);
  endtask

  task automatic do_reset(input logic first_bit);
    Reset = 1'b1;
    sd_in = first_bit;
    repeat (2) begin
      @(posedge Clk);
      #1;
    end
    check_reset_state("reset");
    Reset = 1'b0;
  endtask

  task automatic run_pat(input logic [31:0] pat, input int len, input int n);
    for (int k = 0; k < n; k++) begin
      sd_in = pat[k % len];
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic check_steady(input string tag, input int smp, input int e);
    chk({tag, "_sample"}, int'(sample), smp);
    chk({tag, "_ear"}, int'(ear), e);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Constant ones: also checks the 3-edge sync/feedback latency.
    do_reset(1'b1);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("fb_latency_2", int'(sd_fb), 0);
    @(posedge Clk); #1;
    chk("fb_latency_3", int'(sd_fb), 1);
    run_pat(32'h1, 1, 397);
    check_steady("ones", 511, 1);

    // Constant zeros.
    do_reset(1'b0);
    run_pat(32'h0, 1, 400);
    check_steady("zeros", 0, 0);

    // 50% density: midscale, ear holds its reset value.
    do_reset(1'b1);
    run_pat(32'h1, 2, 400);
    check_steady("half", 256, 0);

    // Density step 0 -> 1.
    do_reset(1'b0);
    run_pat(32'h0, 1, 256);
    check_steady("step_lo", 0, 0);
    run_pat(32'h1, 1, 320);
    check_steady("step_hi", 511, 1);

    // Hysteresis: 3/8, 9/16, 17/32, 15/32 ones densities.
    do_reset(1'b1);
    run_pat(32'h0000_0007, 8, 320);
    check_steady("d3_8", 192, 0);
    run_pat(32'h0000_01FF, 16, 320);
    check_steady("d9_16", 288, 1);
    run_pat(32'h0001_FFFF, 32, 320);
    check_steady("d17_32", 272, 1);
    run_pat(32'h0000_7FFF, 32, 320);
    check_steady("d15_32", 240, 0);

    // Reset mid-stream at dcnt=30, then a long all-ones run across integrator wraps.
    do_reset(1'b1);
    run_pat(32'h1, 1, 3*R + 30);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check_reset_state("midreset");
    Reset = 1'b0;
    run_pat(32'h1, 1, 20000);
    check_steady("long_ones", 511, 1);

    @(negedge Clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
